// File: rtl/rgb2gray_pkg.sv
// rgb2gray_pkg: shared mode encoding, default coefficients and sum-width helper
package rgb2gray_pkg;
  typedef enum logic [1:0] {MODE_R, MODE_G, MODE_B, MODE_LUMA} mode_t;
  localparam int DEFAULT_CR = 77;
  localparam int DEFAULT_CG = 150;
  localparam int DEFAULT_CB = 29;
  function automatic int sum_w(input int width, input int coef_w);
    return width + coef_w + 2;
  endfunction
endpackage

// File: rtl/rgb2gray_pipe_if.sv
// rgb2gray_pipe_if: pixel stream in/out with valid/ready and sof/eol sideband
interface rgb2gray_pipe_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] r_data_in, g_data_in, b_data_in, data_out;
  logic in_valid, in_sof, in_eol, in_ready;
  logic out_valid, out_sof, out_eol, out_ready;
  modport master(
    output r_data_in, g_data_in, b_data_in, in_valid, in_sof, in_eol, out_ready,
    input in_ready, data_out, out_valid, out_sof, out_eol
  );
  modport slave(
    input r_data_in, g_data_in, b_data_in, in_valid, in_sof, in_eol, out_ready,
    output in_ready, data_out, out_valid, out_sof, out_eol
  );
endinterface

// File: rtl/gray_luma_mac.sv
// gray_luma_mac: two-stage multiply then sum/round/saturate, with pass-through bypass
module gray_luma_mac import rgb2gray_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [WIDTH-1:0]  r,
  input  logic [WIDTH-1:0]  g,
  input  logic [WIDTH-1:0]  b,
  input  logic [COEF_W-1:0] cr,
  input  logic [COEF_W-1:0] cg,
  input  logic [COEF_W-1:0] cb,
  input  logic              byp,
  input  logic [WIDTH-1:0]  byp_val,
  output logic [WIDTH-1:0]  y
);
  localparam int PW = WIDTH + COEF_W;
  localparam int SW = sum_w(WIDTH, COEF_W);
  localparam logic [SW-1:0] HALF = SW'(1) << (COEF_W - 1);
  localparam logic [SW-1:0] MAXS = SW'({WIDTH{1'b1}});
  logic [PW-1:0] pr, pg, pb;
  logic byp2;
  logic [WIDTH-1:0] bv2;
  logic [SW-1:0] sum, sh;
  always_comb begin
    sum = SW'(pr) + SW'(pg) + SW'(pb) + HALF;
    sh = sum >> COEF_W;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pr <= '0;
      pg <= '0;
      pb <= '0;
      byp2 <= 1'b0;
      bv2 <= '0;
      y <= '0;
    end else if (en) begin
      pr <= PW'(r) * PW'(cr);
      pg <= PW'(g) * PW'(cg);
      pb <= PW'(b) * PW'(cb);
      byp2 <= byp;
      bv2 <= byp_val;
      y <= byp2 ? bv2 : (sh > MAXS) ? '1 : sh[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/rgb2gray_pipe.sv
// rgb2gray_pipe: 3-stage RGB-to-gray converter with backpressure and frame-aligned config
module rgb2gray_pipe import rgb2gray_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int COEF_W = 8,
  parameter int DEF_CR = DEFAULT_CR,
  parameter int DEF_CG = DEFAULT_CG,
  parameter int DEF_CB = DEFAULT_CB
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [COEF_W-1:0] cfg_cr,
  input  logic [COEF_W-1:0] cfg_cg,
  input  logic [COEF_W-1:0] cfg_cb,
  input  logic              cfg_we,
  output logic              cfg_pending,
  rgb2gray_pipe_if.slave    px
);
  typedef struct packed {
    mode_t mode;
    logic [COEF_W-1:0] cr, cg, cb;
  } cfg_t;
  localparam cfg_t DEF = '{MODE_LUMA, COEF_W'(DEF_CR), COEF_W'(DEF_CG), COEF_W'(DEF_CB)};
  cfg_t act, shd, wr, eff;
  logic adv, acc, v1, v2, v3, s1, s2, s3, e1, e2, e3, byp1;
  logic [WIDTH-1:0] r1, g1, b1, bv1;
  logic [COEF_W-1:0] cr1, cg1, cb1;
  // a sof pixel already runs on the config it activates, including one written this cycle
  always_comb begin
    wr = '{mode_t'(mode), cfg_cr, cfg_cg, cfg_cb};
    eff = px.in_sof ? (cfg_we ? wr : shd) : act;
    adv = !v3 || px.out_ready;
    acc = px.in_valid && adv;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      act <= DEF;
      shd <= DEF;
      cfg_pending <= 1'b0;
      {v1, v2, v3, s1, s2, s3, e1, e2, e3, byp1} <= '0;
      {r1, g1, b1, bv1, cr1, cg1, cb1} <= '0;
    end else begin
      if (cfg_we) shd <= wr;
      if (acc && px.in_sof) act <= eff;
      cfg_pending <= (acc && px.in_sof) ? 1'b0 : (cfg_we || cfg_pending);
      if (adv) begin
        v1 <= px.in_valid;
        s1 <= px.in_valid && px.in_sof;
        e1 <= px.in_valid && px.in_eol;
        {v2, s2, e2} <= {v1, s1, e1};
        {v3, s3, e3} <= {v2, s2, e2};
        r1 <= px.r_data_in;
        g1 <= px.g_data_in;
        b1 <= px.b_data_in;
        cr1 <= eff.cr;
        cg1 <= eff.cg;
        cb1 <= eff.cb;
        byp1 <= eff.mode != MODE_LUMA;
        bv1 <= eff.mode == MODE_R ? px.r_data_in : eff.mode == MODE_G ? px.g_data_in : px.b_data_in;
      end
    end
  end
  gray_luma_mac #(.WIDTH(WIDTH), .COEF_W(COEF_W)) u_mac (
    .clk(clk), .reset(reset), .en(adv),
    .r(r1), .g(g1), .b(b1), .cr(cr1), .cg(cg1), .cb(cb1),
    .byp(byp1), .byp_val(bv1), .y(px.data_out)
  );
  assign px.in_ready = adv;
  assign px.out_valid = v3;
  assign px.out_sof = s3;
  assign px.out_eol = e3;
endmodule

// File: tb/tb_rgb2gray_pipe.sv
// tb_rgb2gray_pipe: randomized + directed scoreboard bench against a plain-arithmetic gray model
module tb_rgb2gray_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] mode;
  logic [7:0] cfg_cr, cfg_cg, cfg_cb;
  logic cfg_we, cfg_pending;
  always #5 clk = ~clk;
  rgb2gray_pipe_if #(.WIDTH(8)) px();
  rgb2gray_pipe #(.WIDTH(8), .COEF_W(8)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .cfg_cr(cfg_cr), .cfg_cg(cfg_cg), .cfg_cb(cfg_cb), .cfg_we(cfg_we),
    .cfg_pending(cfg_pending), .px(px)
  );
  typedef struct {int mode; int cr; int cg; int cb;} cfg_t;
  typedef struct {int d; int sof; int eol;} item_t;
  item_t q[$];
  cfg_t act, shd;
  int pend;
  int tests = 0;
  int fails = 0;
  int last_ov, last_acc;
  int held = 0;
  int hold_d = 0;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic int ref_gray(input int r, input int g, input int b, input cfg_t c);
    int y;
    if (c.mode == 0) return r;
    if (c.mode == 1) return g;
    if (c.mode == 2) return b;
    y = (r * c.cr + g * c.cg + b * c.cb + 128) / 256;
    return (y > 255) ? 255 : y;
  endfunction

  // monitor: pops the scoreboard on each output transfer and watches stall stability
  always @(negedge clk) begin
    if (reset) held = 0;
    else begin
      if (held != 0) begin
        check("stall_valid", int'(px.out_valid), 1);
        check("stall_data", int'(px.data_out), hold_d);
      end
      if (px.out_valid && px.out_ready) begin
        if (q.size() == 0) check("unexpected_output", 1, 0);
        else begin
          item_t it;
          it = q.pop_front();
          check("data_out", int'(px.data_out), it.d);
          check("out_sof", int'(px.out_sof), it.sof);
          check("out_eol", int'(px.out_eol), it.eol);
        end
      end
      if (!px.out_valid) begin
        check("idle_sof", int'(px.out_sof), 0);
        check("idle_eol", int'(px.out_eol), 0);
      end
      held = (px.out_valid && !px.out_ready) ? 1 : 0;
      hold_d = int'(px.data_out);
    end
  end

  task automatic drive(input int v, input int r, input int g, input int b, input int sof,
                       input int eol, input int we, input int md, input int cr, input int cg,
                       input int cb, input int ordy);
    cfg_t w;
    item_t it;
    px.in_valid = v[0];
    px.r_data_in = 8'(r);
    px.g_data_in = 8'(g);
    px.b_data_in = 8'(b);
    px.in_sof = sof[0];
    px.in_eol = eol[0];
    cfg_we = we[0];
    mode = 2'(md);
    cfg_cr = 8'(cr);
    cfg_cg = 8'(cg);
    cfg_cb = 8'(cb);
    px.out_ready = ordy[0];
    @(negedge clk);
    last_ov = int'(px.out_valid);
    if (reset) begin
      q.delete();
      act = '{3, 77, 150, 29};
      shd = act;
      pend = 0;
      last_acc = 0;
    end else begin
      check("in_ready", int'(px.in_ready), int'(!(px.out_valid && !px.out_ready)));
      check("cfg_pending", int'(cfg_pending), pend);
      last_acc = (v != 0 && px.in_ready) ? 1 : 0;
      w = '{md, cr, cg, cb};
      if (we != 0) begin
        shd = w;
        pend = 1;
      end
      if (last_acc != 0 && sof != 0) begin
        act = shd;
        pend = 0;
      end
      if (last_acc != 0) begin
        it.d = ref_gray(r, g, b, act);
        it.sof = sof;
        it.eol = eol;
        q.push_back(it);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int ordy);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    int idx, c, vp;
    reset = 1'b1;
    idle(1);
    idle(1);
    reset = 1'b0;
    check("rst_out_valid", int'(px.out_valid), 0);
    check("rst_data_out", int'(px.data_out), 0);
    check("rst_out_sof", int'(px.out_sof), 0);
    check("rst_out_eol", int'(px.out_eol), 0);
    check("rst_in_ready", int'(px.in_ready), 1);
    check("rst_cfg_pending", int'(cfg_pending), 0);
    // default luma, latency of exactly 3 cycles
    drive(1, 255, 255, 255, 1, 0, 0, 3, 0, 0, 0, 1);
    check("accept_first", last_acc, 1);
    idle(1);
    check("lat_cycle1", last_ov, 0);
    idle(1);
    check("lat_cycle2", last_ov, 0);
    idle(1);
    check("lat_cycle3", last_ov, 1);
    drive(1, 100, 50, 200, 0, 0, 0, 3, 0, 0, 0, 1);
    drain();
    // mid-frame mode change waits for the next sof
    drive(0, 0, 0, 0, 0, 0, 1, 0, 77, 150, 29, 1);
    drive(1, 10, 20, 30, 0, 0, 0, 3, 0, 0, 0, 1);
    drive(1, 10, 20, 30, 1, 0, 0, 3, 0, 0, 0, 1);
    idle(1);
    drain();
    // saturation with heavy coefficients
    drive(0, 0, 0, 0, 0, 0, 1, 3, 200, 200, 200, 1);
    drive(1, 128, 128, 128, 1, 0, 0, 3, 0, 0, 0, 1);
    drain();
    // backpressure pattern 1,0,0,1 while streaming 8 pixels
    idx = 0;
    c = 0;
    while (idx < 8 && c < 100) begin
      drive(1, 30 * idx + 5, 255 - 20 * idx, 17 * idx, (idx == 0) ? 1 : 0, 0,
            (idx == 0) ? 1 : 0, 3, 77, 150, 29, (c % 4 == 0 || c % 4 == 3) ? 1 : 0);
      if (last_acc != 0) idx++;
      c++;
    end
    check("stream_accepted", idx, 8);
    drain();
    // bubbles at cycles 2 and 5, eol on the 4th pixel
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      vp = (k == 2 || k == 5) ? 0 : 1;
      drive(vp, 11 * k, 7 * k, 3 * k, 0, (vp == 1 && idx == 3) ? 1 : 0, 0, 0, 0, 0, 0, 1);
      if (vp == 1) idx++;
    end
    drain();
    // reset with pixels in flight after switching to a pass-through mode
    drive(1, 1, 2, 3, 1, 0, 1, 0, 10, 10, 10, 1);
    drive(1, 4, 5, 6, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 7, 8, 9, 0, 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("rst_flush_valid", int'(px.out_valid), 0);
    check("rst_flush_pending", int'(cfg_pending), 0);
    idle(1);
    check("rst_flush_next", last_ov, 0);
    drive(1, 100, 50, 200, 0, 0, 0, 0, 0, 0, 0, 1);
    drain();
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 4 != 0) ? 1 : 0, int'($urandom_range(255)), int'($urandom_range(255)),
            int'($urandom_range(255)), ($urandom % 12 == 0) ? 1 : 0, ($urandom % 8 == 0) ? 1 : 0,
            ($urandom % 20 == 0) ? 1 : 0, int'($urandom_range(3)), int'($urandom_range(255)),
            int'($urandom_range(255)), int'($urandom_range(255)), ($urandom % 3 != 0) ? 1 : 0);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
